faulty_mem_bank: RTL

Parametrised multi-bank, bit-addressed memory model with a programmable fault table. It is the DUT-side memory for the MBIST top: the BIST engine issues word reads and writes at arbitrary bit columns, and this block returns data corrupted by stuck-at and transition faults. The fault table replaces fixed, hard-coded error insertion and is loaded at run time through a side port. Simulation-oriented; the array is not intended for synthesis at default sizes.

---
 rtl/faulty_mem_bank_pkg.sv | 27 ++
 rtl/faulty_mem_bank_if.sv | 38 +++
 rtl/faulty_mem_bank_flt_match.sv | 48 ++++
 rtl/faulty_mem_bank.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/faulty_mem_bank_pkg.sv
// Shared types for the MBIST fault-injection memory: fault kinds, table entry
// layout and the hit-counter width.
package mbist_pkg;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'd0,
    FLT_SA0   = 2'd1,
    FLT_SA1   = 2'd2,
    FLT_TF_UP = 2'd3
  } flt_type_e;

  localparam int HIT_W = 16;

  // Entry fields are sized for the widest supported geometry and zero-extended
  // from the instance's actual address widths.
  localparam int FLT_BANK_W_MAX = 8;
  localparam int FLT_ROW_W_MAX  = 16;
  localparam int FLT_COL_W_MAX  = 16;

  typedef struct packed {
    flt_type_e                  ftype;
    logic [FLT_BANK_W_MAX-1:0]  bank;
    logic [FLT_ROW_W_MAX-1:0]   row;
    logic [FLT_COL_W_MAX-1:0]   col;
  } flt_entry_t;

endpackage

// File: rtl/faulty_mem_bank_if.sv
// Access bus and fault-table side port of faulty_mem_bank.
interface faulty_mem_bank_if #(
  parameter int BANK_W = 1,
  parameter int ROW_W  = 10,
  parameter int COL_W  = 10,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
);
  logic              ce;
  logic              we;
  logic [BANK_W-1:0] bank_addr;
  logic [ROW_W-1:0]  row_addr;
  logic [COL_W-1:0]  col_addr;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic              rd_valid;
  logic              addr_err;

  logic              flt_we;
  logic [IDX_W-1:0]  flt_idx;
  logic [1:0]        flt_type;
  logic [BANK_W-1:0] flt_bank;
  logic [ROW_W-1:0]  flt_row;
  logic [COL_W-1:0]  flt_col;
  logic [15:0]       flt_hits;

  modport master (
    output ce, we, bank_addr, row_addr, col_addr, data_i,
    output flt_we, flt_idx, flt_type, flt_bank, flt_row, flt_col,
    input  data_o, rd_valid, addr_err, flt_hits
  );

  modport slave (
    input  ce, we, bank_addr, row_addr, col_addr, data_i,
    input  flt_we, flt_idx, flt_type, flt_bank, flt_row, flt_col,
    output data_o, rd_valid, addr_err, flt_hits
  );
endinterface

// File: rtl/faulty_mem_bank_flt_match.sv
// Per-bit fault lookup for one word access: stuck-at force masks and the
// transition-fault mask, lowest table index winning on a shared cell.
module flt_match
  import mbist_pkg::*;
#(
  parameter int BANK_W = 1,
  parameter int ROW_W  = 10,
  parameter int COL_W  = 10,
  parameter int DATA_W = 8,
  parameter int N_FLT  = 8
) (
  input  logic [BANK_W-1:0] bank,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  flt_entry_t        flt_table [N_FLT],
  output logic [DATA_W-1:0] force_en,
  output logic [DATA_W-1:0] force_val,
  output logic [DATA_W-1:0] tfup_mask
);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit
      logic [COL_W-1:0] bit_col;
      flt_type_e        hit_type;

      // Column addition wraps within the row by construction of COL_W.
      assign bit_col = col + COL_W'(gi);

      always_comb begin
        hit_type = FLT_NONE;
        for (int i = N_FLT - 1; i >= 0; i--) begin
          if (flt_table[i].ftype != FLT_NONE &&
              flt_table[i].bank == FLT_BANK_W_MAX'(bank) &&
              flt_table[i].row  == FLT_ROW_W_MAX'(row) &&
              flt_table[i].col  == FLT_COL_W_MAX'(bit_col)) begin
            hit_type = flt_table[i].ftype;
          end
        end
      end

      assign force_en[DATA_W-1-gi]  = (hit_type == FLT_SA0) || (hit_type == FLT_SA1);
      assign force_val[DATA_W-1-gi] = (hit_type == FLT_SA1);
      assign tfup_mask[DATA_W-1-gi] = (hit_type == FLT_TF_UP);
    end
  endgenerate

endmodule

// File: rtl/faulty_mem_bank.sv
// Multi-bank, bit-addressed memory model that corrupts accesses according to a
// run-time programmable table of stuck-at and transition faults.
module faulty_mem_bank
  import mbist_pkg::*;
#(
  parameter int BANKS  = 2,
  parameter int ROW_W  = 10,
  parameter int COL_W  = 10,
  parameter int DATA_W = 8,
  parameter int N_FLT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  faulty_mem_bank_if.slave  bus
);

  localparam int BANK_W   = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int ROW_BITS = 2 ** COL_W;
  localparam int ROWS     = 2 ** ROW_W;

  logic [ROW_BITS-1:0] mem [BANKS][ROWS];
  flt_entry_t          flt_table_reg [N_FLT];

  logic [DATA_W-1:0]   data_o_reg;
  logic                rd_valid_reg;
  logic                addr_err_reg;
  logic [HIT_W-1:0]    flt_hits_reg;

  logic                bank_ok;
  logic [BANK_W-1:0]   bank_sel;
  logic [ROW_BITS-1:0] row_raw;
  logic [ROW_BITS-1:0] row_wr_next;
  logic [COL_W-1:0]    bit_col [DATA_W];
  logic [DATA_W-1:0]   raw_word;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   hit_bits;
  logic [HIT_W:0]      hit_cnt;
  logic [HIT_W:0]      hits_sum;
  logic [HIT_W-1:0]    hits_next;
  logic [DATA_W-1:0]   force_en;
  logic [DATA_W-1:0]   force_val;
  logic [DATA_W-1:0]   tfup_mask;

  assign bank_ok  = int'(bus.bank_addr) < BANKS;
  // Out-of-range banks are steered to bank 0; the access itself is suppressed.
  assign bank_sel = bank_ok ? bus.bank_addr : '0;
  assign row_raw  = mem[bank_sel][bus.row_addr];

  flt_match #(
    .BANK_W (BANK_W),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .DATA_W (DATA_W),
    .N_FLT  (N_FLT)
  ) u_flt_match (
    .bank      (bus.bank_addr),
    .row       (bus.row_addr),
    .col       (bus.col_addr),
    .flt_table (flt_table_reg),
    .force_en  (force_en),
    .force_val (force_val),
    .tfup_mask (tfup_mask)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_col
      assign bit_col[gi]            = bus.col_addr + COL_W'(gi);
      assign raw_word[DATA_W-1-gi]  = row_raw[bit_col[gi]];
    end
  endgenerate

  // A TF_UP cell holding 0 refuses a rising write; every other bit stores.
  always_comb begin
    row_wr_next = row_raw;
    for (int k = 0; k < DATA_W; k++) begin
      if (!(tfup_mask[DATA_W-1-k] && !row_raw[bit_col[k]] && bus.data_i[DATA_W-1-k])) begin
        row_wr_next[bit_col[k]] = bus.data_i[DATA_W-1-k];
      end
    end
  end

  assign rd_word  = (raw_word & ~force_en) | (force_en & force_val);
  assign hit_bits = force_en & (force_val ^ raw_word);

  always_comb begin
    hit_cnt = '0;
    for (int k = 0; k < DATA_W; k++) begin
      hit_cnt = hit_cnt + {{HIT_W{1'b0}}, hit_bits[k]};
    end
  end

  assign hits_sum  = {1'b0, flt_hits_reg} + hit_cnt;
  assign hits_next = hits_sum[HIT_W] ? '1 : hits_sum[HIT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst && bus.ce && bus.we && bank_ok) begin
      mem[bank_sel][bus.row_addr] <= row_wr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o_reg   <= '0;
      rd_valid_reg <= 1'b0;
      addr_err_reg <= 1'b0;
      flt_hits_reg <= '0;
      for (int i = 0; i < N_FLT; i++) begin
        flt_table_reg[i] <= '0;
      end
    end else begin
      rd_valid_reg <= 1'b0;
      addr_err_reg <= 1'b0;
      if (bus.flt_we && int'(bus.flt_idx) < N_FLT) begin
        flt_table_reg[bus.flt_idx] <= '{
          ftype: flt_type_e'(bus.flt_type),
          bank:  FLT_BANK_W_MAX'(bus.flt_bank),
          row:   FLT_ROW_W_MAX'(bus.flt_row),
          col:   FLT_COL_W_MAX'(bus.flt_col)
        };
      end
      if (bus.ce) begin
        if (!bank_ok) begin
          addr_err_reg <= 1'b1;
          if (!bus.we) begin
            data_o_reg   <= '0;
            rd_valid_reg <= 1'b1;
          end
        end else if (!bus.we) begin
          data_o_reg   <= rd_word;
          rd_valid_reg <= 1'b1;
          flt_hits_reg <= hits_next;
        end
      end
    end
  end

  assign bus.data_o   = data_o_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.addr_err = addr_err_reg;
  assign bus.flt_hits = flt_hits_reg;

endmodule
